// File: rtl/ram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctrl_if
// Description : Command, write-beat, read-beat and ram16k access signals of
//               the burst sequencer, with controller (slave) and user
//               (master) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_burst_ctrl_if #(
    parameter int AW   = 14,
    parameter int DW   = 16,
    parameter int LENW = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_wr;
    logic [AW-1:0]   cmd_addr;
    logic [LENW-1:0] cmd_len;
    logic [DW-1:0]   wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            done;
    logic            ram_en;
    logic            ram_r;
    logic            ram_w;
    logic [AW-1:0]   ram_add;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, ram_dout,
        output cmd_ready, wr_ready, rd_data, rd_valid, done,
               ram_en, ram_r, ram_w, ram_add, ram_din
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len, wr_data, wr_valid, ram_dout,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done,
               ram_en, ram_r, ram_w, ram_add, ram_din
    );
endinterface
`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Burst sequencer mastering a ram16k single-port memory; expands
//               write/read commands into one registered access per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_ctrl #(
    parameter int AW     = 14,
    parameter int DW     = 16,
    parameter int LENW   = 8,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    ram_burst_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cur_addr;
    logic [LENW-1:0] r_beats_left;
    logic            r_ram_en;
    logic            r_ram_w;
    logic [AW-1:0]   r_ram_add;
    logic [DW-1:0]   r_ram_din;
    logic [RD_LAT-1:0] r_rd_pipe;

    logic            w_accept;
    logic            w_wr_beat;
    logic            w_rd_issue;
    logic            w_rd_on_bus;
    logic            w_rd_pending;

    assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_rd_on_bus = r_ram_en && !r_ram_w;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_beat   = 1'b0;
        w_rd_issue  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_nxt = bus.cmd_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                // The last write still sits on the ram bus; DRAIN lets it land
                // before done is raised.
                if (bus.wr_valid) begin
                    w_wr_beat = 1'b1;
                    if (r_beats_left == '0) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_READ: begin
                w_rd_issue = 1'b1;
                if (r_beats_left == '0) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_rd_pending) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_ram_en     <= 1'b0;
            r_ram_w      <= 1'b0;
            r_ram_add    <= '0;
            r_ram_din    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ram_en <= w_wr_beat || w_rd_issue;
            r_ram_w  <= w_wr_beat;
            if (w_accept) begin
                r_cur_addr   <= bus.cmd_addr;
                r_beats_left <= bus.cmd_len;
            end
            if (w_wr_beat || w_rd_issue) begin
                r_ram_add    <= r_cur_addr;
                r_cur_addr   <= r_cur_addr + AW'(1);
                r_beats_left <= r_beats_left - LENW'(1);
            end
            if (w_wr_beat) begin
                r_ram_din <= bus.wr_data;
            end
        end
    end

    // Read-return tracker: the final stage marks the cycle ram_dout holds a beat,
    // earlier stages plus a read on the bus are still in flight.
    generate
        if (RD_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= w_rd_on_bus;
                end
            end
            assign w_rd_pending = w_rd_on_bus;
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_pipe <= '0;
                end else begin
                    r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], w_rd_on_bus};
                end
            end
            assign w_rd_pending = w_rd_on_bus || (|r_rd_pipe[RD_LAT-2:0]);
        end
    endgenerate

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.wr_ready  = (r_state == S_WRITE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.rd_valid  = r_rd_pipe[RD_LAT-1];
    assign bus.rd_data   = bus.ram_dout;
    assign bus.ram_en    = r_ram_en;
    assign bus.ram_r     = r_ram_en;
    assign bus.ram_w     = r_ram_w;
    assign bus.ram_add   = r_ram_add;
    assign bus.ram_din   = r_ram_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_ctrl
// Description : Bench for ram_burst_ctrl with a ram16k model and cycle-tagged
//               write/read scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_ctrl;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   last_done = -1;
    logic wr_mode = 1'b0;

    ram_burst_ctrl_if #(.AW(14), .DW(16), .LENW(8)) bus ();

    ram_burst_ctrl #(.AW(14), .DW(16), .LENW(8), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [0:16383];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_w) mem[bus.ram_add] <= bus.ram_din;
            else           bus.ram_dout     <= mem[bus.ram_add];
        end
    end

    typedef struct { logic [13:0] addr; logic [15:0] data; int cyc; } wr_exp_t;
    typedef struct { logic [15:0] data; int cyc; } rd_exp_t;
    wr_exp_t exp_wr[$];
    rd_exp_t exp_rd[$];
    logic [15:0] ref_mem [0:16383];

    typedef struct {
        logic        wr;
        logic [13:0] addr;
        logic [7:0]  len;
        logic [15:0] base;
        logic [15:0] step;
        logic [7:0]  pat;
        int          exp_done;
    } vec_t;
    vec_t tbl [10];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail_ev(input string nm, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %h expected no such event (cycle %0d)", nm, act, cyc);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            wr_exp_t we;
            rd_exp_t re;
            if (bus.ram_en) begin
                chk("ram_r", bus.ram_r, 1);
                if (bus.ram_w) begin
                    if (exp_wr.size() == 0) fail_ev("unexpected_write", bus.ram_add);
                    else begin
                        we = exp_wr.pop_front();
                        chk("wr_addr", bus.ram_add, we.addr);
                        chk("wr_data", bus.ram_din, we.data);
                        chk("wr_cycle", cyc, we.cyc);
                    end
                end else if (wr_mode) begin
                    fail_ev("read_in_write_burst", bus.ram_add);
                end
            end else begin
                chk("ram_idle_rw", {bus.ram_r, bus.ram_w}, 0);
            end
            if (bus.rd_valid) begin
                if (exp_rd.size() == 0) fail_ev("unexpected_rd_valid", bus.rd_data);
                else begin
                    re = exp_rd.pop_front();
                    chk("rd_data", bus.rd_data, re.data);
                    chk("rd_cycle", cyc, re.cyc);
                end
            end
            if (bus.done) begin
                done_cnt++;
                last_done = cyc;
                chk("cmd_ready_in_done", bus.cmd_ready, 0);
            end
        end
    end

    // Called just after a rising edge; returns #1 after the accepting edge.
    task automatic do_cmd(input logic wr, input logic [13:0] addr, input logic [7:0] len,
                          output int acc);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_ev("cmd_accept_timeout", t);
        @(posedge clk);
        #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_cycle);
        int st = done_cnt;
        int t  = 0;
        while (done_cnt == st && t < 600) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (done_cnt == st) fail_ev("done_timeout", t);
        else begin
            chk("done_cycle", last_done, exp_cycle);
            @(negedge clk);
            #1;
            chk("done_width", bus.done, 0);
            chk("done_count", done_cnt - st, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int a;
        int n    = int'(v.len) + 1;
        int sent = 0;
        int i    = 0;
        logic [13:0] ad;
        wr_mode = v.wr;
        do_cmd(v.wr, v.addr, v.len, a);
        if (v.wr) begin
            while (sent < n && i < 512) begin
                bus.wr_valid = v.pat[i % 8];
                bus.wr_data  = v.base + 16'(sent) * v.step;
                if (bus.wr_valid) begin
                    ad = v.addr + 14'(sent);
                    exp_wr.push_back('{ad, bus.wr_data, cyc + 1});
                    ref_mem[ad] = bus.wr_data;
                    sent++;
                end
                @(negedge clk);
                chk("wr_ready", bus.wr_ready, 1);
                @(posedge clk);
                #1;
                i++;
            end
            bus.wr_valid = 1'b0;
        end else begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'hDEAD;
            for (int j = 0; j < n; j++) begin
                ad = v.addr + 14'(j);
                exp_rd.push_back('{ref_mem[ad], a + 2 + j});
            end
        end
        wait_done(a + v.exp_done);
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int st;
        logic [13:0] ad;
        tbl[0] = '{1'b1, 14'h0002, 8'd3,  16'h0002, 16'h0800, 8'hFF, 5};
        tbl[1] = '{1'b0, 14'h0002, 8'd3,  16'h0000, 16'h0000, 8'hFF, 6};
        tbl[2] = '{1'b1, 14'h3FFE, 8'd3,  16'hA000, 16'h0111, 8'hFF, 5};
        tbl[3] = '{1'b0, 14'h3FFE, 8'd3,  16'h0000, 16'h0000, 8'hFF, 6};
        tbl[4] = '{1'b1, 14'h0100, 8'd3,  16'h5500, 16'h0001, 8'h59, 8};
        tbl[5] = '{1'b0, 14'h0100, 8'd3,  16'h0000, 16'h0000, 8'hFF, 6};
        tbl[6] = '{1'b1, 14'h1234, 8'd0,  16'hBEEF, 16'h0000, 8'hFF, 2};
        tbl[7] = '{1'b0, 14'h1234, 8'd0,  16'h0000, 16'h0000, 8'hFF, 3};
        tbl[8] = '{1'b1, 14'h2000, 8'd15, 16'hC000, 16'h0101, 8'hFF, 17};
        tbl[9] = '{1'b0, 14'h2000, 8'd15, 16'h0000, 16'h0000, 8'hFF, 18};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_wr_ready",  bus.wr_ready, 0);
        chk("rst_rd_valid",  bus.rd_valid, 0);
        chk("rst_done",      bus.done, 0);
        chk("rst_ram_ctl",   {bus.ram_en, bus.ram_r, bus.ram_w}, 0);
        chk("rst_ram_add",   bus.ram_add, 0);
        chk("rst_ram_din",   bus.ram_din, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 10; k++) run_vec(tbl[k]);

        // Reset during beat 3 of an 8-beat read.
        wr_mode = 1'b0;
        do_cmd(1'b0, 14'h2000, 8'd7, a);
        for (int j = 0; j < 8; j++) begin
            ad = 14'h2000 + 14'(j);
            exp_rd.push_back('{ref_mem[ad], a + 2 + j});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rd.delete();
        st = done_cnt;
        @(negedge clk);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_ram_en",    bus.ram_en, 0);
        chk("abort_rd_valid",  bus.rd_valid, 0);
        chk("abort_wr_ready",  bus.wr_ready, 0);
        chk("abort_ram_add",   bus.ram_add, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt, st);
        @(posedge clk);
        #1;
        run_vec(tbl[1]);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
